lut_loader: RTL and testbench
=============================

Name: lut_loader

Overview:
- Sequencer and arbiter for the 10-bit branch-target LUT; sits between the CPU fetch/branch logic and the LUT instance.
- Accepts whole 10-bit entries through a valid/ready port and splits each entry into the LUT's two-write protocol: low byte first, then high 2 bits via Load_Hi.
- Shares the LUT address port between loader writes and CPU target lookups.
- Issues one-cycle LUT clear pulses on request.

Parameters:
- W, 10, LUT entry width; fixed at 10 because the high write carries exactly 2 bits.
- A, 4, LUT address width; 2**A entries.

Ports:
- clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- Ld_Valid  in  1  load entry valid
- Ld_Ready  out  1  loader can accept an entry this cycle
- Ld_Addr  in  A  explicit entry address; used when Ld_Auto=0 and for Ptr_Load
- Ld_Data  in  W  10-bit entry value
- Ld_Auto  in  1  1: use the internal auto-increment pointer instead of Ld_Addr
- Ptr_Load  in  1  load the internal pointer from Ld_Addr; accepted only in IDLE
- Clear_Req  in  1  request a full LUT clear
- Cpu_Addr  in  A  CPU lookup index
- Cpu_Lookup  in  1  CPU wants a target this cycle
- Cpu_Stall  out  1  CPU lookup blocked by loader activity
- Lut_Addr  out  A  drives the LUT address/index input
- Lut_Wr_En  out  1  drives the LUT write enable
- Lut_Load_Hi  out  1  drives the LUT high-bits select
- Lut_Acc  out  8  drives the LUT accumulator/data input
- Lut_Reset  out  1  drives the LUT synchronous clear
- Busy  out  1  state is not IDLE

Behaviour:
- **Reset.** Reset_n low asynchronously forces: state IDLE, pointer 0, captured addr/data 0. All outputs are 0 except Ld_Ready=1 and Lut_Addr=Cpu_Addr. Reset mid-entry abandons the entry; a half-written low byte may remain in the LUT.
- **States:** IDLE, CLEAR, WR_LO, WR_HI. All outputs below are registered-state decodes, combinational from state.
- **IDLE**
  - Outputs: Ld_Ready=1, Lut_Addr=Cpu_Addr, write/reset strobes 0.
  - Priority: Clear_Req > Ld_Valid > Ptr_Load.
  - Clear_Req -> CLEAR; Ld_Ready drops that cycle, so a simultaneous Ld_Valid is not accepted.
  - Ld_Valid -> capture entry and go to WR_LO. Captured addr = pointer if Ld_Auto, else Ld_Addr.
  - Ptr_Load without Ld_Valid -> pointer <= Ld_Addr.
- **CLEAR:** Lut_Reset=1 for exactly one cycle, Ld_Ready=0, then IDLE. Pointer resets to 0.
- **WR_LO:** Lut_Wr_En=1, Lut_Load_Hi=0, Lut_Addr=captured addr, Lut_Acc=data[7:0], Ld_Ready=0; next WR_HI.
- **WR_HI**
  - Outputs: Lut_Wr_En=1, Lut_Load_Hi=1, Lut_Acc={6'b0,data[9:8]}, Lut_Addr=captured addr, Ld_Ready=1.
  - New Ld_Valid accepted here -> capture and go to WR_LO (back-to-back, 1 entry per 2 cycles); otherwise IDLE.
  - Clear_Req is ignored in WR_HI (held until IDLE); Ptr_Load is ignored.
- **Pointer:** if Ld_Auto is set on the accepted entry, pointer increments at acceptance and wraps from 2**A-1 to 0.
- **Arbitration:**
  - Cpu_Stall = Cpu_Lookup & (state != IDLE).
  - Loader always wins; the CPU holds Cpu_Addr and retries.
- **Latency:** entry fully visible at LUT output 2 clocks after acceptance.
- Handshake follows standard valid/ready: Ld_Data/Ld_Addr stable while Ld_Valid & !Ld_Ready.

Optional Feature:
- Macro: LUT_LOAD_COUNT_EN.
- When defined:
  - Extra output Load_Count[7:0]; increments in each WR_HI cycle, saturates at 255.
  - Clears on reset and on CLEAR.
- When undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package lut_pkg: state enum (IDLE, CLEAR, WR_LO, WR_HI); constants LUT_W=10, LUT_A=4, LUT_LO_W=8, LUT_HI_W=2.
- One natural sub-module, lut_ptr: auto-increment pointer with load, increment and wrap. Everything else is inline.

Test Plan:
- **Single entry.** Reset, then accept Ld_Addr=3, Ld_Data=10'h2A5, Ld_Auto=0.
  - Next cycle: Wr_En=1, Load_Hi=0, Acc=8'hA5, Addr=3.
  - Following cycle: Load_Hi=1, Acc=8'h02.
  - LUT[3]=10'h2A5.
- **Auto burst with wrap.** Ptr_Load Ld_Addr=14, then stream 3 entries back-to-back with Ld_Auto=1.
  - Writes land at 14, 15, 0; Ld_Ready stays 1 every other cycle.
  - Pointer ends at 1.
- **Lookup stall.** Cpu_Lookup=1, Cpu_Addr=5 during a load.
  - Cpu_Stall=1 exactly in WR_LO/WR_HI.
  - Lut_Addr returns to 5 in IDLE.
- **Clear priority.** Clear_Req and Ld_Valid in the same IDLE cycle.
  - Lut_Reset pulses one cycle; the entry is not accepted until Ld_Ready returns.
  - Pointer is 0 afterwards.
- **Async reset mid-entry.** Drop Reset_n during WR_LO without a clock edge.
  - Outputs go to reset values immediately; state IDLE after release.
- **Count saturation (with LUT_LOAD_COUNT_EN).** Load 260 entries.
  - Load_Count=255; CLEAR sets it to 0.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared constants and state encoding for the branch-target LUT loader.
package lut_pkg;

  localparam int LUT_W    = 10;
  localparam int LUT_A    = 4;
  localparam int LUT_LO_W = 8;
  localparam int LUT_HI_W = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_WR_LO = 2'd2;
  localparam state_t ST_WR_HI = 2'd3;

endpackage

// File: rtl/lut_loader_if.sv
// Load, CPU lookup and LUT drive signals of the LUT loader.
// Load_Count is present only when LUT_LOAD_COUNT_EN is defined.
interface lut_loader_if #(
  parameter int A = 4,
  parameter int W = 10
);
  logic         Ld_Valid;
  logic         Ld_Ready;
  logic [A-1:0] Ld_Addr;
  logic [W-1:0] Ld_Data;
  logic         Ld_Auto;
  logic         Ptr_Load;
  logic         Clear_Req;
  logic [A-1:0] Cpu_Addr;
  logic         Cpu_Lookup;
  logic         Cpu_Stall;
  logic [A-1:0] Lut_Addr;
  logic         Lut_Wr_En;
  logic         Lut_Load_Hi;
  logic [7:0]   Lut_Acc;
  logic         Lut_Reset;
  logic         Busy;
`ifdef LUT_LOAD_COUNT_EN
  logic [7:0]   Load_Count;
`endif

  modport master (
    output Ld_Valid, Ld_Addr, Ld_Data, Ld_Auto, Ptr_Load, Clear_Req,
           Cpu_Addr, Cpu_Lookup,
`ifdef LUT_LOAD_COUNT_EN
    input  Load_Count,
`endif
    input  Ld_Ready, Cpu_Stall, Lut_Addr, Lut_Wr_En, Lut_Load_Hi,
           Lut_Acc, Lut_Reset, Busy
  );

  modport slave (
    input  Ld_Valid, Ld_Addr, Ld_Data, Ld_Auto, Ptr_Load, Clear_Req,
           Cpu_Addr, Cpu_Lookup,
`ifdef LUT_LOAD_COUNT_EN
    output Load_Count,
`endif
    output Ld_Ready, Cpu_Stall, Lut_Addr, Lut_Wr_En, Lut_Load_Hi,
           Lut_Acc, Lut_Reset, Busy
  );

endinterface

// File: rtl/lut_ptr.sv
// Auto-increment LUT address pointer: clear, load, increment with natural wrap.
module lut_ptr
  import lut_pkg::*;
#(
  parameter int A = LUT_A
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  input  logic [A-1:0] load_val,
  output logic [A-1:0] ptr
);

  logic [A-1:0] ptr_q, ptr_d;

  // Clear beats load beats increment; increment wraps 2**A-1 -> 0 by overflow.
  always_comb begin
    ptr_d = ptr_q;
    if (clr)       ptr_d = '0;
    else if (load) ptr_d = load_val;
    else if (inc)  ptr_d = ptr_q + 1'b1;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/lut_loader.sv
// Branch-target LUT loader: splits 10-bit entries into low/high LUT writes,
// arbitrates the LUT address between loader and CPU, and issues clear pulses.
// Optional write counter enabled by LUT_LOAD_COUNT_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | CPU owns Lut_Addr; accepts clear, entry or pointer load
//   CLEAR    | one-cycle Lut_Reset pulse; pointer returns to 0
//   WR_LO    | write low byte of captured entry
//   WR_HI    | write high 2 bits; may accept the next entry
module lut_loader
  import lut_pkg::*;
#(
  parameter int W = LUT_W,
  parameter int A = LUT_A
) (
  input  logic  clk,
  input  logic  Reset_n,
  lut_loader_if.slave bus
);

  state_t       state_q, state_d;
  logic [A-1:0] addr_q, addr_d;
  logic [W-1:0] data_q, data_d;
  logic [A-1:0] ptr;
  logic         ptr_load, ptr_inc, ptr_clr;
  logic         ld_ready;

  // A pending clear blocks acceptance in IDLE so it cannot race an entry.
  assign ld_ready = ((state_q == ST_IDLE) && !bus.Clear_Req) || (state_q == ST_WR_HI);

  // Next-state, entry capture and pointer control.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ptr_load = 1'b0;
    ptr_inc  = 1'b0;
    ptr_clr  = (state_q == ST_CLEAR);
    case (state_q)
      ST_IDLE: begin
        if (bus.Clear_Req) begin
          state_d = ST_CLEAR;
        end else if (bus.Ld_Valid) begin
          state_d = ST_WR_LO;
          addr_d  = bus.Ld_Auto ? ptr : bus.Ld_Addr;
          data_d  = bus.Ld_Data;
          ptr_inc = bus.Ld_Auto;
        end else if (bus.Ptr_Load) begin
          ptr_load = 1'b1;
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_WR_LO: state_d = ST_WR_HI;
      ST_WR_HI: begin
        if (bus.Ld_Valid) begin
          state_d = ST_WR_LO;
          addr_d  = bus.Ld_Auto ? ptr : bus.Ld_Addr;
          data_d  = bus.Ld_Data;
          ptr_inc = bus.Ld_Auto;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured entry registers.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  lut_ptr #(.A(A)) u_ptr (
    .clk      (clk),
    .rst_n    (Reset_n),
    .clr      (ptr_clr),
    .load     (ptr_load),
    .inc      (ptr_inc),
    .load_val (bus.Ld_Addr),
    .ptr      (ptr)
  );

  // LUT drive: decoded from state only, CPU address whenever the loader is not writing.
  always_comb begin
    bus.Lut_Addr    = bus.Cpu_Addr;
    bus.Lut_Wr_En   = 1'b0;
    bus.Lut_Load_Hi = 1'b0;
    bus.Lut_Acc     = 8'h00;
    bus.Lut_Reset   = 1'b0;
    case (state_q)
      ST_CLEAR: bus.Lut_Reset = 1'b1;
      ST_WR_LO: begin
        bus.Lut_Addr  = addr_q;
        bus.Lut_Wr_En = 1'b1;
        bus.Lut_Acc   = data_q[LUT_LO_W-1:0];
      end
      ST_WR_HI: begin
        bus.Lut_Addr    = addr_q;
        bus.Lut_Wr_En   = 1'b1;
        bus.Lut_Load_Hi = 1'b1;
        bus.Lut_Acc     = {{(LUT_LO_W-LUT_HI_W){1'b0}}, data_q[W-1:LUT_LO_W]};
      end
      default: ;
    endcase
  end

  assign bus.Ld_Ready  = ld_ready;
  assign bus.Busy      = (state_q != ST_IDLE);
  assign bus.Cpu_Stall = bus.Cpu_Lookup && (state_q != ST_IDLE);

`ifdef LUT_LOAD_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Saturating count of completed entries (one per WR_HI cycle).
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_CLEAR)                           cnt_d = 8'h00;
    else if ((state_q == ST_WR_HI) && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'h01;
  end

  // Counter register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= 8'h00;
    else          cnt_q <= cnt_d;
  end

  assign bus.Load_Count = cnt_q;
`endif

endmodule

// File: tb/tb_lut_loader.sv
// Directed bench for lut_loader with a behavioural model of the LUT it drives.
module tb_lut_loader;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_acc;
  int   a0, a1, a2, nlog;

  logic [9:0] lut_m [16];
  logic [3:0] wr_log [$];

  lut_loader_if #(.A(4), .W(10)) bus ();

  lut_loader u_dut (
    .clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // LUT model: synchronous clear, low-byte write, then high-2-bit write.
  always @(posedge clk) begin
    if (bus.Lut_Reset) begin
      for (int i = 0; i < 16; i++) lut_m[i] <= 10'h000;
    end else if (bus.Lut_Wr_En) begin
      if (bus.Lut_Load_Hi) lut_m[bus.Lut_Addr][9:8] <= bus.Lut_Acc[1:0];
      else                 lut_m[bus.Lut_Addr][7:0] <= bus.Lut_Acc;
    end
  end

  // Record the address of every low-byte write.
  always @(posedge clk) begin
    if (bus.Lut_Wr_En && !bus.Lut_Load_Hi) wr_log.push_back(bus.Lut_Addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present an entry and wait (bounded) for acceptance; returns 1ns after the accepting edge.
  task automatic push(input logic [3:0] a, input logic [9:0] d, input logic auto, input logic keep);
    logic ok;
    ok = 1'b0;
    bus.Ld_Valid = 1'b1;
    bus.Ld_Addr  = a;
    bus.Ld_Data  = d;
    bus.Ld_Auto  = auto;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.Ld_Ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("push_accept", {31'd0, ok}, 32'd1);
    last_acc = cyc;
    @(posedge clk);
    #1;
    if (!keep) bus.Ld_Valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut_m[i] = 10'h000;
    rst_n          = 1'b0;
    bus.Ld_Valid   = 1'b0;
    bus.Ld_Addr    = 4'd0;
    bus.Ld_Data    = 10'h000;
    bus.Ld_Auto    = 1'b0;
    bus.Ptr_Load   = 1'b0;
    bus.Clear_Req  = 1'b0;
    bus.Cpu_Addr   = 4'd7;
    bus.Cpu_Lookup = 1'b0;
    #2;
    chk("rst_ready",   32'(bus.Ld_Ready),  32'd1);
    chk("rst_lutaddr", 32'(bus.Lut_Addr),  32'd7);
    chk("rst_wren",    32'(bus.Lut_Wr_En), 32'd0);
    chk("rst_busy",    32'(bus.Busy),      32'd0);
    chk("rst_lutrst",  32'(bus.Lut_Reset), 32'd0);
    chk("rst_acc",     32'(bus.Lut_Acc),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Single explicit entry.
    push(4'd3, 10'h2A5, 1'b0, 1'b0);
    @(negedge clk);
    chk("lo_wren",  32'(bus.Lut_Wr_En),   32'd1);
    chk("lo_hi",    32'(bus.Lut_Load_Hi), 32'd0);
    chk("lo_acc",   32'(bus.Lut_Acc),     32'hA5);
    chk("lo_addr",  32'(bus.Lut_Addr),    32'd3);
    chk("lo_ready", 32'(bus.Ld_Ready),    32'd0);
    step();
    @(negedge clk);
    chk("hi_hi",    32'(bus.Lut_Load_Hi), 32'd1);
    chk("hi_acc",   32'(bus.Lut_Acc),     32'h02);
    chk("hi_addr",  32'(bus.Lut_Addr),    32'd3);
    chk("hi_ready", 32'(bus.Ld_Ready),    32'd1);
    step();
    @(negedge clk);
    chk("lut3",      32'(lut_m[3]),  32'h2A5);
    chk("idle_busy", 32'(bus.Busy),  32'd0);

    // Auto-increment burst wrapping past 15.
    step();
    bus.Ld_Addr  = 4'd14;
    bus.Ptr_Load = 1'b1;
    step();
    bus.Ptr_Load = 1'b0;
    wr_log.delete();
    push(4'd0, 10'h101, 1'b1, 1'b1); a0 = last_acc;
    push(4'd0, 10'h2F0, 1'b1, 1'b1); a1 = last_acc;
    push(4'd0, 10'h0C3, 1'b1, 1'b0); a2 = last_acc;
    step();
    step();
    @(negedge clk);
    chk("burst_n",    32'(wr_log.size()), 32'd3);
    chk("burst_a0",   32'(wr_log[0]),     32'd14);
    chk("burst_a1",   32'(wr_log[1]),     32'd15);
    chk("burst_a2",   32'(wr_log[2]),     32'd0);
    chk("burst_gap1", 32'(a1 - a0),       32'd2);
    chk("burst_gap2", 32'(a2 - a1),       32'd2);
    chk("lut14",      32'(lut_m[14]),     32'h101);
    chk("lut15",      32'(lut_m[15]),     32'h2F0);
    chk("lut0",       32'(lut_m[0]),      32'h0C3);
    step();
    push(4'd9, 10'h111, 1'b1, 1'b0);
    step();
    step();
    chk("ptr_after_wrap", 32'(wr_log[wr_log.size()-1]), 32'd1);
    chk("lut1",           32'(lut_m[1]),                32'h111);

    // CPU lookup stalled by a load.
    bus.Cpu_Addr   = 4'd5;
    bus.Cpu_Lookup = 1'b1;
    @(negedge clk);
    chk("stall_idle0", 32'(bus.Cpu_Stall), 32'd0);
    chk("addr_idle0",  32'(bus.Lut_Addr),  32'd5);
    push(4'd9, 10'h3FF, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_lo",    32'(bus.Cpu_Stall), 32'd1);
    chk("addr_lo",     32'(bus.Lut_Addr),  32'd9);
    step();
    @(negedge clk);
    chk("stall_hi",    32'(bus.Cpu_Stall), 32'd1);
    step();
    @(negedge clk);
    chk("stall_idle1", 32'(bus.Cpu_Stall), 32'd0);
    chk("addr_idle1",  32'(bus.Lut_Addr),  32'd5);
    chk("lut9",        32'(lut_m[9]),      32'h3FF);
    bus.Cpu_Lookup = 1'b0;

    // Clear wins over a simultaneous entry.
    step();
    nlog = wr_log.size();
    bus.Clear_Req = 1'b1;
    bus.Ld_Valid  = 1'b1;
    bus.Ld_Addr   = 4'd2;
    bus.Ld_Data   = 10'h155;
    bus.Ld_Auto   = 1'b0;
    @(negedge clk);
    chk("clr_req_ready", 32'(bus.Ld_Ready), 32'd0);
    step();
    bus.Clear_Req = 1'b0;
    @(negedge clk);
    chk("clr_pulse",  32'(bus.Lut_Reset), 32'd1);
    chk("clr_ready",  32'(bus.Ld_Ready),  32'd0);
    chk("clr_busy",   32'(bus.Busy),      32'd1);
    step();
    @(negedge clk);
    chk("clr_end",    32'(bus.Lut_Reset),     32'd0);
    chk("clr_ready2", 32'(bus.Ld_Ready),      32'd1);
    chk("clr_nowr",   32'(wr_log.size()),     32'(nlog));
    chk("clr_lut3",   32'(lut_m[3]),          32'h000);
    step();
    bus.Ld_Valid = 1'b0;
    @(negedge clk);
    chk("clr_entry_addr", 32'(bus.Lut_Addr), 32'd2);
    step();
    step();
    chk("lut2", 32'(lut_m[2]), 32'h155);
    push(4'd9, 10'h077, 1'b1, 1'b0);
    step();
    step();
    chk("ptr_after_clr", 32'(wr_log[wr_log.size()-1]), 32'd0);

    // Asynchronous reset in the middle of an entry.
    bus.Cpu_Addr = 4'd12;
    push(4'd6, 10'h0AA, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_wren", 32'(bus.Lut_Wr_En), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wren",  32'(bus.Lut_Wr_En), 32'd0);
    chk("arst_ready", 32'(bus.Ld_Ready),  32'd1);
    chk("arst_busy",  32'(bus.Busy),      32'd0);
    chk("arst_addr",  32'(bus.Lut_Addr),  32'd12);
    chk("arst_acc",   32'(bus.Lut_Acc),   32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy",  32'(bus.Busy),     32'd0);
    chk("post_rst_ready", 32'(bus.Ld_Ready), 32'd1);
    push(4'd6, 10'h0AA, 1'b0, 1'b0);
    step();
    step();
    chk("post_rst_lut6", 32'(lut_m[6]), 32'h0AA);

`ifdef LUT_LOAD_COUNT_EN
    // Saturating write counter and its clear.
    for (int i = 0; i < 259; i++) push(4'(i), 10'(i), 1'b0, 1'b1);
    push(4'd0, 10'h000, 1'b0, 1'b0);
    step();
    step();
    chk("count_sat", 32'(bus.Load_Count), 32'd255);
    bus.Clear_Req = 1'b1;
    step();
    bus.Clear_Req = 1'b0;
    step();
    @(negedge clk);
    chk("count_clr", 32'(bus.Load_Count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
